spi_cnn_bridge: RTL and testbench
=================================

Name: spi_cnn_bridge

Overview:
Parametrised SPI-slave bridge between the external SPI pins and the CNN core. It replaces the fixed single-pixel SPI control path. It decodes a command byte per chip-select frame and supports four operations: pixel write, kernel-coefficient write, result read and status read. Traffic is tagged with a channel index. Both directions are buffered in FIFOs with valid/ready handshakes toward the core, and sticky error flags report overflow, underflow and bad commands.

Parameters:
PIXEL_BITS, 8, width of input pixels and result words on SPI and core side
KERNEL_BITS, 8, width of one kernel coefficient
KERNEL_TAPS, 9, coefficients per kernel (3x3)
NUM_CH, 4, number of channels (1..4); channel field is 2 bits
IN_DEPTH, 4, input pixel FIFO depth (power of 2, >=2)
OUT_DEPTH, 4, result FIFO depth (power of 2, >=2)
SYNC_STAGES, 2, synchronizer flops on sck/cs/sdi

Ports:
clk_i  in  1  system clock
reset_i  in  1  synchronous active-high reset
spi_sck_i  in  1  SPI clock, mode 0, asynchronous to clk_i
spi_cs_i  in  1  chip select, active low
spi_sdi_i  in  1  serial data in, MSB first
spi_sdo_o  out  1  serial data out, MSB first
px_o  out  PIXEL_BITS  input pixel to core (FIFO head)
px_ch_o  out  2  channel of px_o
px_valid_o  out  1  px_o valid
px_ready_i  in  1  core accepts px_o
coef_o  out  KERNEL_BITS  kernel coefficient
coef_idx_o  out  clog2(KERNEL_TAPS)  tap index of coef_o
coef_ch_o  out  2  channel of coefficient/kernel
coef_we_o  out  1  one-cycle coefficient write strobe
kernel_valid_o  out  1  one-cycle pulse: full kernel loaded
res_px_i  in  PIXEL_BITS  result pixel from core
res_valid_i  in  1  result valid
res_ready_o  out  1  result FIFO not full

Behaviour:
- Reset values: spi_sdo_o=0; px_valid_o=0; coef_we_o=0; kernel_valid_o=0; coef_idx_o=0. FIFOs are emptied and sticky flags cleared. res_ready_o=!out_full, so it is 1 while reset is held.
- sck/cs/sdi each pass through SYNC_STAGES flops. sck rise/fall are detected on the synchronized signal. SPI clock must be <= clk_i/4.
- sdi is sampled on a detected sck rise. sdo is updated on a detected sck fall. A word completes on the rise of its last bit.
- FSM states: IDLE, CMD, WR_PX, WR_COEF, RD_RES, RD_STAT, IGNORE.
- IDLE->CMD on synchronized cs falling edge. Bit counter=0.
- CMD: collect 8 bits. Field cmd[7:6] is the opcode: 00 WR_PX, 01 WR_COEF, 10 RD_RES, 11 RD_STAT. Field cmd[5:4] is the channel; cmd[3:0] is ignored. If channel>=NUM_CH, go to IGNORE and set the cmd_err flag.
- Any state->IDLE on cs high. A partial word is discarded, the bit counter is cleared and sdo returns to 0.
- WR_PX: each completed PIXEL_BITS word is pushed {ch,word} into the in-FIFO the cycle after completion. px_valid_o rises on the next cycle if the FIFO was empty (2 clk after the final sck rise).
- In-FIFO full on push: word dropped, ovf flag set. A push on the same cycle as a pop while full is accepted.
- px pop occurs when px_valid_o && px_ready_i. FIFO order is preserved across channels.
- WR_COEF: coefficient index resets to 0 at frame start. Each completed word drives coef_o/coef_idx_o/coef_ch_o with a one-cycle coef_we_o, then increments the index.
- On the strobe for index KERNEL_TAPS-1, kernel_valid_o pulses in the same cycle. Words beyond KERNEL_TAPS are ignored with no strobe.
- RD_RES: at CMD completion and after each word boundary, the out-FIFO head is popped into the shift register and its MSB is driven on sdo immediately. The register shifts on each sck fall.
- Out-FIFO empty at load: shift register loaded with 0, udf flag set.
- Out-FIFO push occurs when res_valid_i && res_ready_o.
- RD_STAT: the shift register loads the status byte {ovf, udf, cmd_err, in_empty, in_full, out_empty, out_full, 1}, followed by zeros.
- Sticky flags clear when the 8th status bit completes. An event in that same cycle wins and leaves the flag set.
- IGNORE: sdo=0 and no strobes until cs high.
- Reset mid-frame: FSM goes to IDLE and the current frame is ignored until cs is seen high, then low again.

Test Plan:
1. Reset, then frame cmd 0x10 + pixels 0x12,0x34 with px_ready_i=1 -> px_o=0x12 then 0x34, px_ch_o=1, px_valid_o rises 2 clk after each final sck rise.
2. px_ready_i=0, cmd 0x00 + 6 pixels (IN_DEPTH=4) -> first 4 retained in order, ovf=1. A later status read returns bit7=1, and the next status read returns bit7=0.
3. Cmd 0x60 + 10 coefficients 1..10 -> 9 coef_we_o strobes (idx 0..8, ch 2, values 1..9), kernel_valid_o pulse with idx 8, 10th word ignored.
4. Core pushes 0xA5,0x3C; cmd 0x80 + 3 read words -> sdo returns 0xA5, 0x3C, 0x00, and udf=1.
5. cs raised after 5 bits of a pixel word -> no push. Next frame cmd 0x30 with NUM_CH=2 -> IGNORE, cmd_err=1, sdo stays 0.
6. reset_i asserted mid-WR_PX -> all outputs return to reset values, FIFOs empty, and the remaining bits of that frame produce no push.

Source files
------------

// File: rtl/spi_cnn_bridge.sv
// SPI-slave command bridge to the CNN core: pixel/kernel writes, result/status reads,
// buffered in both directions with sticky overflow/underflow/command error flags.
module spi_cnn_bridge #(
  parameter int unsigned PIXEL_BITS  = 8,
  parameter int unsigned KERNEL_BITS = 8,
  parameter int unsigned KERNEL_TAPS = 9,
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned IN_DEPTH    = 4,
  parameter int unsigned OUT_DEPTH   = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           spi_sck_i,
  input  logic                           spi_cs_i,
  input  logic                           spi_sdi_i,
  output logic                           spi_sdo_o,
  output logic [PIXEL_BITS-1:0]          px_o,
  output logic [1:0]                     px_ch_o,
  output logic                           px_valid_o,
  input  logic                           px_ready_i,
  output logic [KERNEL_BITS-1:0]         coef_o,
  output logic [$clog2(KERNEL_TAPS)-1:0] coef_idx_o,
  output logic [1:0]                     coef_ch_o,
  output logic                           coef_we_o,
  output logic                           kernel_valid_o,
  input  logic [PIXEL_BITS-1:0]          res_px_i,
  input  logic                           res_valid_i,
  output logic                           res_ready_o
);

  localparam int unsigned WMax = (PIXEL_BITS > KERNEL_BITS) ? PIXEL_BITS : KERNEL_BITS;
  localparam int unsigned DW   = (WMax > 8) ? WMax : 8;
  localparam int unsigned CW   = $clog2(DW + 1);
  localparam int unsigned IW   = $clog2(KERNEL_TAPS);
  localparam int unsigned TW   = $clog2(KERNEL_TAPS + 1);
  localparam int unsigned IAW  = $clog2(IN_DEPTH);
  localparam int unsigned OAW  = $clog2(OUT_DEPTH);
  localparam logic [2:0]    NumChW  = 3'(NUM_CH);
  localparam logic [TW-1:0] TapsW   = TW'(KERNEL_TAPS);
  localparam logic [TW-1:0] LastTap = TW'(KERNEL_TAPS - 1);

  typedef enum logic [2:0] {
    StIdle, StCmd, StWrPx, StWrCoef, StRdRes, StRdStat, StIgnore
  } state_e;

  // Synchronizers; the cs chain resets low so a frame already in progress at reset
  // never yields a falling edge and stays ignored until cs cycles high then low.
  logic [SYNC_STAGES-1:0] r_sck_sync, r_cs_sync, r_sdi_sync;
  logic                   r_sck_prev, r_cs_prev;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_sck_sync <= '0;
      r_cs_sync  <= '0;
      r_sdi_sync <= '0;
      r_sck_prev <= 1'b0;
      r_cs_prev  <= 1'b0;
    end else begin
      r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck_i};
      r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_i};
      r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], spi_sdi_i};
      r_sck_prev <= r_sck_sync[SYNC_STAGES-1];
      r_cs_prev  <= r_cs_sync[SYNC_STAGES-1];
    end
  end

  logic w_sck_s, w_cs_s, w_sdi_s, w_sck_rise, w_sck_fall, w_cs_fall;
  assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
  assign w_cs_s     = r_cs_sync[SYNC_STAGES-1];
  assign w_sdi_s    = r_sdi_sync[SYNC_STAGES-1];
  assign w_sck_rise = w_sck_s & ~r_sck_prev;
  assign w_sck_fall = ~w_sck_s & r_sck_prev;
  assign w_cs_fall  = ~w_cs_s & r_cs_prev;

  state_e                r_state;
  logic [CW-1:0]         r_bit_cnt;
  logic [DW-2:0]         r_shift_in;
  logic [DW-1:0]         r_shift_out;
  logic [1:0]            r_ch;
  logic                  r_px_push;
  logic [PIXEL_BITS+1:0] r_px_wdata;
  logic [TW-1:0]         r_tap;
  logic [KERNEL_BITS-1:0] r_coef;
  logic [IW-1:0]         r_coef_idx;
  logic [1:0]            r_coef_ch;
  logic                  r_coef_we, r_kv, r_stat_first;
  logic                  r_ovf, r_udf, r_cmd_err;

  // Input pixel FIFO, entries {ch, pixel}
  logic [PIXEL_BITS+1:0] r_in_mem [IN_DEPTH];
  logic [IAW:0]          r_in_wp, r_in_rp;
  logic                  w_in_empty, w_in_full, w_px_pop, w_in_push, w_ovf_set;

  assign w_in_empty = (r_in_wp == r_in_rp);
  assign w_in_full  = (r_in_wp[IAW] != r_in_rp[IAW]) &&
                      (r_in_wp[IAW-1:0] == r_in_rp[IAW-1:0]);
  assign w_px_pop   = !w_in_empty && px_ready_i;
  assign w_in_push  = r_px_push && (!w_in_full || w_px_pop);
  assign w_ovf_set  = r_px_push && w_in_full && !w_px_pop;
  assign px_valid_o = !w_in_empty;
  assign {px_ch_o, px_o} = r_in_mem[r_in_rp[IAW-1:0]];

  always_ff @(posedge clk_i) begin
    if (w_in_push) r_in_mem[r_in_wp[IAW-1:0]] <= r_px_wdata;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_in_wp <= '0;
      r_in_rp <= '0;
    end else begin
      if (w_in_push) r_in_wp <= r_in_wp + 1'b1;
      if (w_px_pop)  r_in_rp <= r_in_rp + 1'b1;
    end
  end

  // Result FIFO
  logic [PIXEL_BITS-1:0] r_out_mem [OUT_DEPTH];
  logic [OAW:0]          r_out_wp, r_out_rp;
  logic                  w_out_empty, w_out_full, w_out_push, w_out_pop;
  logic [PIXEL_BITS-1:0] w_out_head;

  assign w_out_empty = (r_out_wp == r_out_rp);
  assign w_out_full  = (r_out_wp[OAW] != r_out_rp[OAW]) &&
                       (r_out_wp[OAW-1:0] == r_out_rp[OAW-1:0]);
  assign w_out_push  = res_valid_i && !w_out_full;
  assign w_out_head  = r_out_mem[r_out_rp[OAW-1:0]];
  assign res_ready_o = !w_out_full;

  always_ff @(posedge clk_i) begin
    if (w_out_push) r_out_mem[r_out_wp[OAW-1:0]] <= res_px_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_out_wp <= '0;
      r_out_rp <= '0;
    end else begin
      if (w_out_push) r_out_wp <= r_out_wp + 1'b1;
      if (w_out_pop)  r_out_rp <= r_out_rp + 1'b1;
    end
  end

  // Word framing
  logic [CW-1:0] w_len;
  logic [DW-1:0] w_word, w_load_val;
  logic [7:0]    w_status;
  logic          w_active, w_reading, w_word_done, w_ch_ok;
  logic          w_res_load, w_stat_cmd, w_stat_load, w_udf_set, w_cmd_err_set, w_stat_clr;

  always_comb begin
    w_len = CW'(8);
    case (r_state)
      StWrPx, StRdRes: w_len = CW'(PIXEL_BITS);
      StWrCoef:        w_len = CW'(KERNEL_BITS);
      default:         ;
    endcase
  end

  assign w_word      = {r_shift_in, w_sdi_s};
  assign w_active    = r_state inside {StCmd, StWrPx, StWrCoef, StRdRes, StRdStat};
  assign w_reading   = r_state inside {StRdRes, StRdStat};
  assign w_word_done = !w_cs_s && w_sck_rise && w_active && (r_bit_cnt == w_len - 1'b1);
  assign w_ch_ok     = ({1'b0, w_word[5:4]} < NumChW);

  assign w_res_load    = w_word_done && ((r_state == StRdRes) ||
                         (r_state == StCmd && w_word[7:6] == 2'b10 && w_ch_ok));
  assign w_stat_cmd    = w_word_done && r_state == StCmd && w_word[7:6] == 2'b11 && w_ch_ok;
  assign w_stat_load   = w_stat_cmd || (w_word_done && r_state == StRdStat);
  assign w_out_pop     = w_res_load && !w_out_empty;
  assign w_udf_set     = w_res_load && w_out_empty;
  assign w_cmd_err_set = w_word_done && r_state == StCmd && !w_ch_ok;
  assign w_stat_clr    = w_word_done && r_state == StRdStat && r_stat_first;
  assign w_status      = {r_ovf, r_udf, r_cmd_err, w_in_empty, w_in_full,
                          w_out_empty, w_out_full, 1'b1};

  // Outgoing words are left-aligned so the MSB always sits at the sdo bit
  always_comb begin
    w_load_val = '0;
    if (w_out_pop)       w_load_val = DW'(w_out_head) << (DW - PIXEL_BITS);
    else if (w_stat_cmd) w_load_val = DW'(w_status) << (DW - 8);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_ovf     <= 1'b0;
      r_udf     <= 1'b0;
      r_cmd_err <= 1'b0;
    end else begin
      r_ovf     <= (r_ovf & ~w_stat_clr) | w_ovf_set;
      r_udf     <= (r_udf & ~w_stat_clr) | w_udf_set;
      r_cmd_err <= (r_cmd_err & ~w_stat_clr) | w_cmd_err_set;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state      <= StIdle;
      r_bit_cnt    <= '0;
      r_shift_in   <= '0;
      r_shift_out  <= '0;
      r_ch         <= '0;
      r_px_push    <= 1'b0;
      r_px_wdata   <= '0;
      r_tap        <= '0;
      r_coef       <= '0;
      r_coef_idx   <= '0;
      r_coef_ch    <= '0;
      r_coef_we    <= 1'b0;
      r_kv         <= 1'b0;
      r_stat_first <= 1'b0;
    end else begin
      r_px_push <= 1'b0;
      r_coef_we <= 1'b0;
      r_kv      <= 1'b0;
      if (w_cs_s) begin
        r_state     <= StIdle;
        r_bit_cnt   <= '0;
        r_shift_out <= '0;
      end else begin
        if (w_sck_rise && w_active) begin
          r_shift_in <= w_word[DW-2:0];
          r_bit_cnt  <= w_word_done ? '0 : r_bit_cnt + 1'b1;
        end
        // No shift on the fall right after a load: the fresh MSB must go out first
        if (w_sck_fall && w_reading && r_bit_cnt != '0) r_shift_out <= r_shift_out << 1;
        if (w_res_load || w_stat_load) r_shift_out <= w_load_val;
        unique case (r_state)
          StIdle: begin
            if (w_cs_fall) begin
              r_state   <= StCmd;
              r_bit_cnt <= '0;
            end
          end
          StCmd: begin
            if (w_word_done) begin
              r_ch <= w_word[5:4];
              if (!w_ch_ok) begin
                r_state <= StIgnore;
              end else begin
                case (w_word[7:6])
                  2'b00: r_state <= StWrPx;
                  2'b01: begin
                    r_state <= StWrCoef;
                    r_tap   <= '0;
                  end
                  2'b10: r_state <= StRdRes;
                  default: begin
                    r_state      <= StRdStat;
                    r_stat_first <= 1'b1;
                  end
                endcase
              end
            end
          end
          StWrPx: begin
            if (w_word_done) begin
              r_px_push  <= 1'b1;
              r_px_wdata <= {r_ch, w_word[PIXEL_BITS-1:0]};
            end
          end
          StWrCoef: begin
            if (w_word_done && r_tap < TapsW) begin
              r_coef     <= w_word[KERNEL_BITS-1:0];
              r_coef_idx <= IW'(r_tap);
              r_coef_ch  <= r_ch;
              r_coef_we  <= 1'b1;
              r_kv       <= (r_tap == LastTap);
              r_tap      <= r_tap + 1'b1;
            end
          end
          StRdStat: begin
            if (w_word_done) r_stat_first <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign spi_sdo_o      = r_shift_out[DW-1];
  assign coef_o         = r_coef;
  assign coef_idx_o     = r_coef_idx;
  assign coef_ch_o      = r_coef_ch;
  assign coef_we_o      = r_coef_we;
  assign kernel_valid_o = r_kv;

endmodule

// File: tb/tb_spi_cnn_bridge.sv
// Scoreboard bench for spi_cnn_bridge: directed SPI frames, expected pixels, coefficient
// strobes and sdo bytes queued at issue time and checked by a free-running monitor.
module tb_spi_cnn_bridge;
  localparam int unsigned SyncStages = 2;
  localparam int          HalfSck    = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, sck, cs, cs2, sdi, px_ready, res_valid;
  logic [7:0] res_px;
  logic       sdo, px_valid, coef_we, kv, res_ready;
  logic [7:0] px, coef;
  logic [1:0] px_ch, coef_ch;
  logic [3:0] coef_idx;
  logic       sdo2, px_valid2, coef_we2, kv2, res_ready2;
  logic [7:0] px2, coef2;
  logic [1:0] px_ch2, coef_ch2;
  logic [3:0] coef_idx2;

  spi_cnn_bridge #(.NUM_CH(4), .SYNC_STAGES(SyncStages)) u_dut (
    .clk_i(clk), .reset_i(reset), .spi_sck_i(sck), .spi_cs_i(cs), .spi_sdi_i(sdi),
    .spi_sdo_o(sdo), .px_o(px), .px_ch_o(px_ch), .px_valid_o(px_valid), .px_ready_i(px_ready),
    .coef_o(coef), .coef_idx_o(coef_idx), .coef_ch_o(coef_ch), .coef_we_o(coef_we),
    .kernel_valid_o(kv), .res_px_i(res_px), .res_valid_i(res_valid), .res_ready_o(res_ready)
  );

  // Two-channel instance with its own chip select, for the bad-channel case
  spi_cnn_bridge #(.NUM_CH(2), .SYNC_STAGES(SyncStages)) u_dut2 (
    .clk_i(clk), .reset_i(reset), .spi_sck_i(sck), .spi_cs_i(cs2), .spi_sdi_i(sdi),
    .spi_sdo_o(sdo2), .px_o(px2), .px_ch_o(px_ch2), .px_valid_o(px_valid2),
    .px_ready_i(1'b1), .coef_o(coef2), .coef_idx_o(coef_idx2), .coef_ch_o(coef_ch2),
    .coef_we_o(coef_we2), .kernel_valid_o(kv2), .res_px_i(8'h00), .res_valid_i(1'b0),
    .res_ready_o(res_ready2)
  );

  typedef struct packed {logic [1:0] ch; logic [7:0] px; logic lat;} px_exp_t;
  typedef struct packed {logic kv; logic [1:0] ch; logic [3:0] idx; logic [7:0] val;} coef_exp_t;

  px_exp_t    px_q[$];
  coef_exp_t  coef_q[$];
  logic [7:0] exp_rx_q[$];
  logic [7:0] rx_q[$];
  int         n_cmp = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         last_rise = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents an output
  always @(negedge clk) begin
    if (!reset) begin
      if (px_valid && px_ready) begin
        if (px_q.size() == 0) check("px_unexpected", {px_ch, px}, 32'hFFFF_FFFF);
        else begin
          px_exp_t e;
          e = px_q.pop_front();
          check("px_data", {px_ch, px}, {e.ch, e.px});
          if (e.lat) check("px_latency", cyc - last_rise, SyncStages + 2);
        end
      end
      if (coef_we || kv) begin
        if (coef_q.size() == 0) check("coef_unexpected", {kv, coef_ch, coef_idx, coef}, 0);
        else begin
          coef_exp_t c;
          c = coef_q.pop_front();
          check("coef_we", coef_we, 1);
          check("coef_word", {kv, coef_ch, coef_idx, coef}, c);
        end
      end
      while (rx_q.size() > 0) check("sdo_byte", rx_q.pop_front(), exp_rx_q.pop_front());
      if (px_valid2 || coef_we2 || kv2) begin
        n_cmp++;
        n_fail++;
        $display("FAIL dut2_strobe: got px=%0h/%0h coef=%0h/%0h/%0h rdy=%b, expected no strobe",
                 px2, px_ch2, coef2, coef_idx2, coef_ch2, res_ready2);
      end
    end
  end

  task automatic spi_bits(input logic [7:0] tx, input int n, input bit use2,
                          output logic [7:0] rx);
    logic [7:0] t;
    t  = tx;
    rx = '0;
    for (int i = 0; i < n; i++) begin
      sdi = t[7];
      t   = {t[6:0], 1'b0};
      repeat (HalfSck) @(negedge clk);
      rx  = {rx[6:0], use2 ? sdo2 : sdo};
      sck = 1'b1;
      last_rise = cyc;
      repeat (HalfSck) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic xfer(input logic [7:0] tx, input logic [7:0] exp, input bit use2);
    logic [7:0] rx;
    spi_bits(tx, 8, use2, rx);
    exp_rx_q.push_back(exp);
    rx_q.push_back(rx);
  endtask

  task automatic cs_low(input bit use2);
    if (use2) cs2 = 1'b0;
    else cs = 1'b0;
    repeat (HalfSck) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (HalfSck) @(negedge clk);
    cs  = 1'b1;
    cs2 = 1'b1;
    repeat (2 * HalfSck) @(negedge clk);
  endtask

  task automatic status_read(input logic [7:0] exp, input bit use2);
    cs_low(use2);
    xfer(8'hC0, 8'h00, use2);
    xfer(8'h00, exp, use2);
    cs_high();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_px_valid"}, px_valid, 0);
    check({tag, "_coef_we"}, coef_we, 0);
    check({tag, "_kernel_valid"}, kv, 0);
    check({tag, "_coef_idx"}, coef_idx, 0);
    check({tag, "_sdo"}, sdo, 0);
    check({tag, "_res_ready"}, res_ready, 1);
  endtask

  initial begin
    logic [7:0] dummy;
    reset = 1'b1; sck = 1'b0; cs = 1'b1; cs2 = 1'b1; sdi = 1'b0;
    px_ready = 1'b1; res_valid = 1'b0; res_px = 8'h00;
    repeat (5) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // 1: two pixels on channel 1, latency checked
    px_q.push_back('{ch: 2'd1, px: 8'h12, lat: 1'b1});
    px_q.push_back('{ch: 2'd1, px: 8'h34, lat: 1'b1});
    cs_low(0);
    xfer(8'h10, 8'h00, 0);
    xfer(8'h12, 8'h00, 0);
    xfer(8'h34, 8'h00, 0);
    cs_high();

    // 2: overflow with core stalled, then sticky ovf read and cleared
    px_ready = 1'b0;
    for (int i = 1; i <= 4; i++) px_q.push_back('{ch: 2'd0, px: 8'(i), lat: 1'b0});
    cs_low(0);
    xfer(8'h00, 8'h00, 0);
    for (int i = 1; i <= 6; i++) xfer(8'(i), 8'h00, 0);
    cs_high();
    status_read(8'h8D, 0);
    status_read(8'h0D, 0);
    px_ready = 1'b1;

    // 3: kernel of 9 taps on channel 2, tenth word ignored
    for (int i = 0; i < 9; i++)
      coef_q.push_back('{kv: (i == 8), ch: 2'd2, idx: 4'(i), val: 8'(i + 1)});
    cs_low(0);
    xfer(8'h60, 8'h00, 0);
    for (int i = 1; i <= 10; i++) xfer(8'(i), 8'h00, 0);
    cs_high();

    // 4: two results read back, third read underflows
    res_px = 8'hA5; res_valid = 1'b1;
    @(negedge clk);
    res_px = 8'h3C;
    @(negedge clk);
    res_valid = 1'b0;
    cs_low(0);
    xfer(8'h80, 8'h00, 0);
    xfer(8'h00, 8'hA5, 0);
    xfer(8'h00, 8'h3C, 0);
    xfer(8'h00, 8'h00, 0);
    cs_high();
    status_read(8'h55, 0);

    // 5: truncated pixel word is discarded; bad channel on the 2-channel instance
    cs_low(0);
    xfer(8'h00, 8'h00, 0);
    spi_bits(8'hF8, 5, 0, dummy);
    cs_high();
    status_read(8'h15, 0);
    cs_low(1);
    xfer(8'h30, 8'h00, 1);
    xfer(8'hAA, 8'h00, 1);
    xfer(8'h55, 8'h00, 1);
    cs_high();
    status_read(8'h35, 1);

    // 6: reset mid-frame with data queued both ways
    cs_low(0);
    xfer(8'h80, 8'h00, 0);
    xfer(8'h00, 8'h00, 0);
    cs_high();
    res_px = 8'h77; res_valid = 1'b1;
    @(negedge clk);
    res_valid = 1'b0;
    px_ready = 1'b0;
    cs_low(0);
    xfer(8'h00, 8'h00, 0);
    xfer(8'h55, 8'h00, 0);
    spi_bits(8'hA0, 3, 0, dummy);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("midreset");
    reset = 1'b0;
    px_ready = 1'b1;
    spi_bits(8'h00, 5, 0, dummy);
    xfer(8'hFF, 8'h00, 0);
    cs_high();
    status_read(8'h15, 0);

    for (int i = 0; i < 4000 && (px_q.size() + coef_q.size() + rx_q.size()) > 0; i++)
      @(negedge clk);
    repeat (10) @(negedge clk);
    check("px_left", px_q.size(), 0);
    check("coef_left", coef_q.size(), 0);
    check("sdo_left", exp_rx_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
